// File: rtl/branch_predict_ctrl.sv
// Branch direction predictor and redirect/flush controller for a 5-stage pipeline.
// BHT of 2-bit saturating counters is looked up in ID and trained from EX resolutions.
module branch_predict_ctrl #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        id_branch,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_target,
  output logic        id_pred_taken,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        brn_en,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush_if,
  output logic        flush_id,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          bht_r [ENTRIES];
  logic [31:0]         br_count_r;
  logic [31:0]         mispred_count_r;
  logic [IDX_BITS-1:0] id_idx_s;
  logic [IDX_BITS-1:0] ex_idx_s;
  logic                mispred_s;
  logic                unused_pc_bits_s;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    logic [1:0] nxt;
    if (up) begin
      nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return nxt;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

  assign id_idx_s  = id_pc[IDX_BITS+1:2];
  assign ex_idx_s  = ex_pc[IDX_BITS+1:2];
  assign mispred_s = ex_branch & (brn_en != ex_pred_taken);
  assign unused_pc_bits_s = ^{id_pc[31:IDX_BITS+2], id_pc[1:0], ex_pc[1:0]};

  // Lookup reads the registered BHT, so an EX update in the same cycle is not visible yet.
  assign id_pred_taken = id_branch & bht_r[id_idx_s][1];
  assign br_count      = br_count_r;
  assign mispred_count = mispred_count_r;

  // BHT training and statistics counters; reset wins over stall and updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_r[i] <= 2'b01;
      end
      br_count_r      <= 32'd0;
      mispred_count_r <= 32'd0;
    end else if (!stall) begin
      if (ex_branch) begin
        bht_r[ex_idx_s] <= sat_step(bht_r[ex_idx_s], brn_en);
        br_count_r      <= sat_inc(br_count_r);
      end
      if (mispred_s) begin
        mispred_count_r <= sat_inc(mispred_count_r);
      end
    end
  end

  // Redirect/flush selection: EX correction outranks an ID predicted-taken jump.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    if (!stall && mispred_s) begin
      redirect    = 1'b1;
      redirect_pc = brn_en ? ex_target : ex_pc + 32'd4;
      flush_if    = 1'b1;
      flush_id    = 1'b1;
    end else if (!stall && id_pred_taken) begin
      redirect    = 1'b1;
      redirect_pc = id_target;
      flush_if    = 1'b1;
      flush_id    = 1'b0;
    end else begin
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      flush_if    = 1'b0;
      flush_id    = 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl (IDX_BITS=4, index = pc[5:2]).
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, id_branch, ex_branch, ex_pred_taken, brn_en;
  logic [31:0] id_pc, id_target, ex_pc, ex_target;
  logic        id_pred_taken, redirect, flush_if, flush_id;
  logic [31:0] redirect_pc, br_count, mispred_count;
  int          total = 0;
  int          bad = 0;

  branch_predict_ctrl #(.IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .id_branch(id_branch), .id_pc(id_pc), .id_target(id_target), .id_pred_taken(id_pred_taken),
    .ex_branch(ex_branch), .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .brn_en(brn_en), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic br, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pt, input logic en);
    ex_branch = br; ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; brn_en = en;
  endtask

  task automatic set_id(input logic br, input logic [31:0] pc, input logic [31:0] tgt);
    id_branch = br; id_pc = pc; id_target = tgt;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    set_id(1'b0, 32'd0, 32'd0);
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // Reset state: weakly not-taken everywhere, counters cleared
    set_id(1'b1, 32'h100, 32'h140);
    #1;
    chk("rst_pred", {31'd0, id_pred_taken}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_br_count", br_count, 32'd0);
    chk("rst_mis_count", mispred_count, 32'd0);

    // First taken resolution predicted not-taken: mispredict to ex_target
    set_id(1'b0, 32'h100, 32'h140);
    set_ex(1'b1, 32'h100, 32'h180, 1'b0, 1'b1);
    #1;
    chk("mp1_redirect", {31'd0, redirect}, 32'd1);
    chk("mp1_pc", redirect_pc, 32'h180);
    chk("mp1_flush_if", {31'd0, flush_if}, 32'd1);
    chk("mp1_flush_id", {31'd0, flush_id}, 32'd1);
    tick();
    chk("mp1_mis_count", mispred_count, 32'd1);
    chk("mp1_br_count", br_count, 32'd1);
    tick();
    // Entry at 0x100 is now 2'b11: ID predicts taken
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    set_id(1'b1, 32'h100, 32'h140);
    #1;
    chk("mp2_pred", {31'd0, id_pred_taken}, 32'd1);
    chk("mp2_br_count", br_count, 32'd2);
    chk("id_redirect", {31'd0, redirect}, 32'd1);
    chk("id_pc", redirect_pc, 32'h140);
    chk("id_flush_if", {31'd0, flush_if}, 32'd1);
    chk("id_flush_id", {31'd0, flush_id}, 32'd0);

    // Predicted taken, actually not-taken at top of address space: fall-through wraps
    set_id(1'b0, 32'd0, 32'd0);
    set_ex(1'b1, 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b0);
    #1;
    chk("wrap_redirect", {31'd0, redirect}, 32'd1);
    chk("wrap_pc", redirect_pc, 32'h0000_0000);
    chk("wrap_flush_id", {31'd0, flush_id}, 32'd1);
    tick();
    chk("wrap_mis_count", mispred_count, 32'd3);

    // EX mispredict and ID predicted-taken together: EX wins
    set_id(1'b1, 32'h100, 32'h300);
    set_ex(1'b1, 32'h104, 32'h200, 1'b0, 1'b1);
    #1;
    chk("prio_id_pred", {31'd0, id_pred_taken}, 32'd1);
    chk("prio_pc", redirect_pc, 32'h200);
    chk("prio_flush_id", {31'd0, flush_id}, 32'd1);
    tick();
    chk("prio_br_count", br_count, 32'd4);

    // Four not-taken updates on 0x100 observed through same-cycle lookup: 11,10,01,00
    set_id(1'b1, 32'h100, 32'h300);
    set_ex(1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
    #1; chk("sat_rbw0", {31'd0, id_pred_taken}, 32'd1);
    chk("sat_nomis_flush_id", {31'd0, flush_id}, 32'd0);
    tick(); chk("sat_rbw1", {31'd0, id_pred_taken}, 32'd1);
    tick(); chk("sat_rbw2", {31'd0, id_pred_taken}, 32'd0);
    tick(); chk("sat_rbw3", {31'd0, id_pred_taken}, 32'd0);
    tick();
    // Saturated at 00: two taken updates needed before predicting taken
    set_ex(1'b1, 32'h100, 32'h200, 1'b1, 1'b1);
    #1; chk("sat_up0", {31'd0, id_pred_taken}, 32'd0);
    tick(); chk("sat_up1", {31'd0, id_pred_taken}, 32'd0);
    tick();
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1; chk("sat_up2", {31'd0, id_pred_taken}, 32'd1);
    chk("sat_br_count", br_count, 32'd10);
    chk("sat_mis_count", mispred_count, 32'd4);

    // Stall during an EX mispredict: no redirect, no training, no counting
    stall = 1'b1;
    set_ex(1'b1, 32'h100, 32'h200, 1'b0, 1'b1);
    #1;
    chk("stall_redirect", {31'd0, redirect}, 32'd0);
    chk("stall_pc", redirect_pc, 32'd0);
    chk("stall_flush_if", {31'd0, flush_if}, 32'd0);
    chk("stall_flush_id", {31'd0, flush_id}, 32'd0);
    tick();
    chk("stall_br_count", br_count, 32'd10);
    chk("stall_mis_count", mispred_count, 32'd4);
    // Entry still 10: one not-taken update drops it below taken
    stall = 1'b0;
    set_ex(1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
    #1; chk("stall_bht_pre", {31'd0, id_pred_taken}, 32'd1);
    tick();
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1; chk("stall_bht_post", {31'd0, id_pred_taken}, 32'd0);

    // Reset mid-sequence with a concurrent EX mispredict; outputs stay combinational
    rst = 1'b1;
    set_id(1'b0, 32'd0, 32'd0);
    set_ex(1'b1, 32'h104, 32'h240, 1'b0, 1'b1);
    #1;
    chk("rst2_redirect", {31'd0, redirect}, 32'd1);
    chk("rst2_pc", redirect_pc, 32'h240);
    tick();
    rst = 1'b0;
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("rst2_br_count", br_count, 32'd0);
    chk("rst2_mis_count", mispred_count, 32'd0);
    for (int i = 0; i < 16; i++) begin
      set_id(1'b1, 32'h100 + 32'(i) * 32'd4, 32'h300);
      #1;
      chk($sformatf("rst2_pred_%0d", i), {31'd0, id_pred_taken}, 32'd0);
    end
    // Entry 1 back at 01: a single taken update makes it predict taken
    set_id(1'b1, 32'h104, 32'h300);
    set_ex(1'b1, 32'h104, 32'h240, 1'b0, 1'b1);
    tick();
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("rst2_wnt_pred", {31'd0, id_pred_taken}, 32'd1);
    chk("rst2_br_after", br_count, 32'd1);
    chk("rst2_mis_after", mispred_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 SHALL have parameter IDX_BITS, default 4, BHT index width (2^IDX_BITS entries).
REQ-002 SHALL have one clock and synchronous active-high reset as: clk  input  1  rising-edge clock.
REQ-003 SHALL have: rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have: stall  input  1  pipeline stall; freezes all state and suppresses redirects.
REQ-005 SHALL have: id_branch  input  1  ID-stage instruction is a conditional branch.
REQ-006 SHALL have: id_pc  input  32  ID-stage instruction PC.
REQ-007 SHALL have: id_target  input  32  ID-stage branch target (pc+imm).
REQ-008 SHALL have: id_pred_taken  output  1  prediction for ID branch.
REQ-009 SHALL have: ex_branch  input  1  EX-stage instruction is a valid conditional branch.
REQ-010 SHALL have: ex_pc  input  32  EX-stage branch PC.
REQ-011 SHALL have: ex_target  input  32  EX-stage branch target.
REQ-012 SHALL have: ex_pred_taken  input  1  prediction carried down the pipe for EX branch.
REQ-013 SHALL have: brn_en  input  1  actual outcome from branch-compare logic.
REQ-014 SHALL have: redirect  output  1  fetch PC override valid this cycle.
REQ-015 SHALL have: redirect_pc  output  32  fetch PC to load when redirect=1.
REQ-016 SHALL have: flush_if  output  1  kill IF/ID register contents.
REQ-017 SHALL have: flush_id  output  1  kill ID/EX register contents.
REQ-018 SHALL have: br_count  output  32  resolved-branch count.
REQ-019 SHALL have: mispred_count  output  32  misprediction count.

Function
REQ-020 SHALL hold a BHT of 2^IDX_BITS 2-bit saturating counters, indexed by pc[IDX_BITS+1:2].
REQ-021 SHALL drive id_pred_taken = id_branch & BHT[id_pc index][1], combinational from registered state.
REQ-022 SHALL define EX mispredict = ex_branch & (brn_en != ex_pred_taken).
REQ-023 SHALL, on EX mispredict with stall=0: redirect=1, flush_if=1, flush_id=1, redirect_pc = brn_en ? ex_target : ex_pc+4 (mod 2^32), same cycle.
REQ-024 SHALL, with no EX mispredict, stall=0 and id_pred_taken=1: redirect=1, redirect_pc=id_target, flush_if=1, flush_id=0.
REQ-025 SHALL give EX mispredict priority over ID predicted-taken redirect in the same cycle.
REQ-026 SHALL otherwise drive redirect=0, flush_if=0, flush_id=0, redirect_pc=0.
REQ-027 SHALL, when stall=1, force redirect/flush outputs to 0 and perform no BHT or counter update.
REQ-028 SHALL, on clock edge with ex_branch=1 and stall=0, update BHT[ex_pc index]: increment if brn_en=1, decrement otherwise, saturating at 2'b11 and 2'b00.
REQ-029 SHALL return the pre-update counter value to an ID lookup at the same index in the same cycle as an EX update (read-before-write).
REQ-030 SHALL increment br_count by 1 per update in REQ-028, saturating at 32'hFFFF_FFFF.
REQ-031 SHALL increment mispred_count by 1 per EX mispredict with stall=0, saturating at 32'hFFFF_FFFF.
REQ-032 SHALL keep all counter/BHT logic free of combinational paths from brn_en to id_pred_taken.

Reset
REQ-033 SHALL, when rst=1 at a clock edge, set every BHT entry to 2'b01 (weakly not-taken), br_count=0, mispred_count=0.
REQ-034 SHALL give rst priority over stall and any concurrent update; redirect/flush outputs follow REQ-023..026 combinationally from inputs, and for one cycle after reset id_pred_taken=0 for all indices.

Verification
REQ-035 SHALL verify: reset, then id_branch=1 at id_pc=0x100 -> id_pred_taken=0; counters 0.
REQ-036 SHALL verify: two EX resolutions ex_pc=0x100, brn_en=1, ex_pred_taken=0 -> first: redirect=1, redirect_pc=ex_target, flush_if=flush_id=1, mispred_count=1; after second, id_pred_taken=1 for id_pc=0x100, br_count=2.
REQ-037 SHALL verify: ex_pred_taken=1, brn_en=0, ex_pc=0xFFFF_FFFC -> redirect_pc=0x0000_0000 (wrap), flush_id=1.
REQ-038 SHALL verify: same cycle EX mispredict (target 0x200) and id_pred_taken=1 (id_target 0x300) -> redirect_pc=0x200, flush_id=1.
REQ-039 SHALL verify: counter at 2'b11, four not-taken updates -> 10,01,00,00 (saturates); stall=1 during an EX mispredict -> no redirect, no count change.
REQ-040 SHALL verify: rst asserted mid-sequence with ex_branch=1 -> next cycle all BHT entries 2'b01, both counts 0.
